// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU under test: holds the core in reset after start, then runs it
// until the fetch PC stalls (halt) or a cycle budget expires (timeout).
module cpu_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned HALT_REPEAT  = 3,
  parameter int unsigned PC_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [PC_W-1:0]  final_pc
);

  localparam int unsigned SMALL_W = 8;

  typedef enum logic [2:0] {IDLE, HOLD, RUN, HALTED, TIMEOUT} state_t;

  state_t             state;
  logic [SMALL_W-1:0] hold_cnt;
  logic [SMALL_W-1:0] rep_cnt;
  logic [PC_W-1:0]    last_pc;
  logic               seeded;

  logic [SMALL_W-1:0] rep_next;
  logic [PC_W-1:0]    last_pc_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               halt_hit;
  logic               max_hit;

  // Halt / budget detection for the current RUN cycle; the first valid pc only seeds.
  always_comb begin
    rep_next     = rep_cnt;
    last_pc_next = last_pc;
    if (pc_valid) begin
      last_pc_next = pc;
      if (seeded && (pc == last_pc)) rep_next = SMALL_W'(rep_cnt + SMALL_W'(1));
      else                           rep_next = '0;
    end
    halt_hit = pc_valid && (rep_next == SMALL_W'(HALT_REPEAT));
    cnt_next = CNT_W'(cycle_count + CNT_W'(1));
    max_hit  = (cnt_next == CNT_W'(MAX_CYCLES));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cpu_reset   <= 1'b1;
      cpu_en      <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      final_pc    <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      last_pc     <= '0;
      seeded      <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      cpu_reset   <= 1'b1;
      cpu_en      <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      final_pc    <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      last_pc     <= '0;
      seeded      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            last_pc     <= '0;
            seeded      <= 1'b0;
            cycle_count <= '0;
          end
        end
        HOLD: begin
          // cpu_reset stays high for RESET_CYCLES full cycles after leaving IDLE.
          if (hold_cnt == SMALL_W'(RESET_CYCLES - 1)) begin
            state       <= RUN;
            cpu_reset   <= 1'b0;
            cpu_en      <= 1'b1;
            running     <= 1'b1;
            cycle_count <= '0;
          end else begin
            hold_cnt <= SMALL_W'(hold_cnt + SMALL_W'(1));
          end
        end
        RUN: begin
          cycle_count <= cnt_next;
          rep_cnt     <= rep_next;
          last_pc     <= last_pc_next;
          seeded      <= seeded | pc_valid;
          if (halt_hit) begin
            state    <= HALTED;
            final_pc <= pc;
            cpu_en   <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b1;
          end else if (max_hit) begin
            state    <= TIMEOUT;
            final_pc <= last_pc_next;
            cpu_en   <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
          end
        end
        HALTED, TIMEOUT: begin
          state <= state;
        end
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
          cpu_en    <= 1'b0;
          running   <= 1'b0;
          done      <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: per-run expected outcome queued by the stimulus, checked by a
// monitor when done rises; directed halt/timeout/gap cases plus random PC streams.
module tb_cpu_run_ctrl;

  localparam int unsigned RC = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned MC = 10;
  localparam int unsigned HR = 3;
  localparam int unsigned PW = 32;

  typedef struct {
    bit          to;
    logic [31:0] fpc;
    logic [15:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, clear, pc_valid;
  logic [PW-1:0] pc;
  logic          cpu_reset, cpu_en, running, done, timeout;
  logic [CW-1:0] cycle_count;
  logic [PW-1:0] final_pc;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic done_q = 1'b0;

  logic [31:0] stim_pc[MC];
  bit          stim_v[MC];

  cpu_run_ctrl #(
    .RESET_CYCLES(RC), .CNT_W(CW), .MAX_CYCLES(MC), .HALT_REPEAT(HR), .PC_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .running(running), .done(done),
    .timeout(timeout), .cycle_count(cycle_count), .final_pc(final_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Outcome of a run: walk the valid PCs, count trailing identical repeats, first to HR wins.
  function automatic exp_t model();
    exp_t        e;
    logic [31:0] last = '0;
    bit          seeded = 0;
    int          rep = 0;
    for (int k = 0; k < int'(MC); k++) begin
      if (stim_v[k]) begin
        if (seeded && stim_pc[k] == last) rep++;
        else rep = 0;
        last   = stim_pc[k];
        seeded = 1;
        if (rep == int'(HR)) begin
          e.to = 0; e.fpc = last; e.cnt = 16'(k + 1);
          return e;
        end
      end
    end
    e.to = 1; e.fpc = last; e.cnt = 16'(MC);
    return e;
  endfunction

  // Monitor: every rising done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_timeout", 64'(timeout), 64'(e.to));
        chk("mon_final_pc", 64'(final_pc), 64'(e.fpc));
        chk("mon_cycle_count", 64'(cycle_count), 64'(e.cnt));
        chk("mon_cpu_en", 64'(cpu_en), 64'(0));
        chk("mon_cpu_reset", 64'(cpu_reset), 64'(0));
        chk("mon_running", 64'(running), 64'(0));
      end
    end
    done_q <= done;
  end

  task automatic chk_idle(input string nm);
    chk({nm, "_cpu_reset"}, 64'(cpu_reset), 64'(1));
    chk({nm, "_cpu_en"}, 64'(cpu_en), 64'(0));
    chk({nm, "_running"}, 64'(running), 64'(0));
    chk({nm, "_done"}, 64'(done), 64'(0));
    chk({nm, "_timeout"}, 64'(timeout), 64'(0));
    chk({nm, "_cycle_count"}, 64'(cycle_count), 64'(0));
    chk({nm, "_final_pc"}, 64'(final_pc), 64'(0));
  endtask

  task automatic start_and_hold();
    @(negedge clk) start = 1'b1;
    for (int i = 0; i < int'(RC); i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("hold_cpu_reset", 64'(cpu_reset), 64'(1));
      chk("hold_cpu_en", 64'(cpu_en), 64'(0));
    end
    @(negedge clk);
    chk("run_cpu_reset", 64'(cpu_reset), 64'(0));
    chk("run_cpu_en", 64'(cpu_en), 64'(1));
    chk("run_running", 64'(running), 64'(1));
    chk("run_cycle_count", 64'(cycle_count), 64'(0));
  endtask

  task automatic run_case();
    exp_t e;
    int   waited;
    e = model();
    q.push_back(e);
    start_and_hold();
    for (int k = 0; k < int'(MC); k++) begin
      if (k > 0) @(negedge clk);
      pc       = stim_pc[k];
      pc_valid = stim_v[k];
    end
    @(negedge clk);
    pc_valid = 1'b0;
    waited = 0;
    while (!done && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    chk("done_within_budget", 64'(done), 64'(1));
    // Sticky: outcome must not move while pc keeps toggling and start is pulsed.
    repeat (3) begin
      @(negedge clk);
      pc = $urandom; pc_valid = 1'b1; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; pc_valid = 1'b0;
    chk("sticky_done", 64'(done), 64'(1));
    chk("sticky_timeout", 64'(timeout), 64'(e.to));
    chk("sticky_cycle_count", 64'(cycle_count), 64'(e.cnt));
    chk("sticky_final_pc", 64'(final_pc), 64'(e.fpc));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_idle("after_clear");
  endtask

  task automatic fill_invalid();
    for (int k = 0; k < int'(MC); k++) begin
      stim_pc[k] = $urandom;
      stim_v[k]  = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; pc = '0; pc_valid = 1'b0;
    #2;
    chk_idle("in_reset");
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    // Halt on 0x3008 repeated
    fill_invalid();
    stim_pc[0] = 32'h3000; stim_pc[1] = 32'h3004;
    for (int k = 2; k < 6; k++) stim_pc[k] = 32'h3008;
    for (int k = 0; k < 6; k++) stim_v[k] = 1;
    run_case();

    // Timeout with incrementing pc
    for (int k = 0; k < int'(MC); k++) begin
      stim_pc[k] = 32'h100 + 32'(4 * k); stim_v[k] = 1;
    end
    run_case();

    // Halt and budget on the same cycle
    for (int k = 0; k < int'(MC); k++) begin
      stim_pc[k] = (k < 6) ? 32'h200 + 32'(4 * k) : 32'h500; stim_v[k] = 1;
    end
    run_case();

    // Invalid gaps between identical pcs
    fill_invalid();
    for (int k = 0; k < 7; k += 2) begin
      stim_pc[k] = 32'h40; stim_v[k] = 1;
    end
    run_case();

    // Differing pc mid-sequence restarts the count
    fill_invalid();
    for (int k = 0; k < 7; k++) begin
      stim_pc[k] = (k < 3) ? 32'h60 : 32'h64; stim_v[k] = 1;
    end
    run_case();

    // Random streams over a small pc alphabet
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < int'(MC); k++) begin
        stim_pc[k] = 32'h10 + 32'(4 * $urandom_range(0, 2));
        stim_v[k]  = ($urandom_range(0, 3) != 0);
      end
      run_case();
    end

    // Async reset mid-RUN aborts the run
    start_and_hold();
    pc = 32'h77; pc_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_idle("async_reset");
    @(negedge clk) reset = 1'b0;
    pc_valid = 1'b0;
    repeat (RC + 2) @(negedge clk);
    chk_idle("after_abort");

    // Start together with clear resolves to clear
    start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    repeat (RC + 2) @(negedge clk);
    chk_idle("start_with_clear");

    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
